lcd_text_feeder: RTL and testbench
==================================

// Module: lcd_text_feeder
// PURPOSE
//   Upstream stage of the LCD driver: holds a 2x16 character screen buffer that a host writes one char at a time.
//   Streams the buffer to the driver as command/data words over the data/selectCD/enableWriting/LCD_Available handshake.
//   Sequence per refresh: line-1 address cmd, 4 char words, line-2 address cmd, 4 char words (10 transfers).
// PARAMETERS
//   REFRESH_CYCLES  50_000_000  period between forced refreshes (only with LCD_AUTO_REFRESH_EN)
//   LINE1_CMD       8'h80       DDRAM set-address command for line 1
//   LINE2_CMD       8'hC0       DDRAM set-address command for line 2
// PORTS
//   clk               in   1   system clock (CLOCK_50)
//   rst               in   1   asynchronous, active-low reset
//   wr_en             in   1   host write strobe, one char per cycle
//   wr_addr           in   5   char position: 0-15 line 1, 16-31 line 2
//   wr_char           in   8   ASCII code
//   busy              out  1   refresh sequence in progress
//   lcd_data          out  32  word to driver
//   lcd_select_cd     out  1   1 = character data, 0 = command
//   lcd_enable_writing out 1   transfer request to driver
//   lcd_available     in   1   driver idle/ready
// BEHAVIOUR
//   Reset (rst low, async): buffer all 8'h20; dirty=1; state IDLE; step=0;
//     lcd_data=0, lcd_select_cd=1, lcd_enable_writing=0, busy=0.
//   Host write: wr_en=1 stores wr_char at wr_addr on the next edge and sets dirty. Accepted in every state.
//   Packing: char word k (k=0..3 per line) = {c[4k],c[4k+1],c[4k+2],c[4k+3]}; leftmost char in [31:24].
//     Command word = {24'h0, CMD}, lcd_select_cd=0.
//   FSM:
//     IDLE     -> REQ when dirty (or refresh tick); clears dirty, step=0, busy=1.
//     REQ      drive word[step] and select_cd, assert enable_writing; -> WAIT_ACK.
//     WAIT_ACK hold enable_writing and word stable until lcd_available=0 (accepted),
//              then drop enable; -> WAIT_RDY.
//     WAIT_RDY wait lcd_available=1; step==9 -> IDLE (busy=0), else step+1 -> REQ.
//   Steps: 0 = LINE1_CMD; 1-4 = chars 0-15; 5 = LINE2_CMD; 6-9 = chars 16-31.
//   Char words sample the buffer in REQ. A write to a char already sent is not lost:
//     the write re-sets dirty, so one more refresh follows.
//   A write in the same cycle IDLE->REQ clears dirty: dirty ends 1 (set wins).
//   lcd_data/select_cd change only in REQ; never while enable_writing=1 in WAIT_ACK.
//   Minimum transfer = 3 cycles (REQ, WAIT_ACK, WAIT_RDY) with an instantly responding driver.
//   Reset mid-sequence aborts immediately: enable dropped, buffer re-blanked, full refresh after release.
// CONFIGURATION
//   LCD_AUTO_REFRESH_EN defined: a free-running counter wraps every REFRESH_CYCLES and raises a refresh tick.
//     The tick is latched into dirty, including when it arrives while busy.
//     This recovers from a driver that lost content.
//   Undefined: no counter; refresh only on host writes and after reset.
// TESTING
//   Reset release, driver always ready -> 10 transfers:
//     80(cmd), 20202020 x4, C0(cmd), 20202020 x4; busy then 0.
//   Write "HELLO" at 0-4 -> word 1 = 48454C4C, word 2 = 4F202020, all select_cd=1; one refresh only.
//   Driver holds lcd_available=1 for 20 cycles after a request -> lcd_enable_writing and lcd_data stable for all 20.
//   Write addr 2 during step 7 -> current sequence completes, a second full refresh shows the new char.
//   Reset low during step 4 -> enable_writing=0 same cycle.
//     After release: full blank-screen sequence from step 0.
//   With LCD_AUTO_REFRESH_EN, REFRESH_CYCLES=100, no writes -> a refresh starts every 100 cycles; without it, none after the first.

Source files
------------

// File: rtl/lcd_text_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_text_feeder                                              |
// | Description : Upstream stage of the LCD driver. Holds a 2x16 character     |
// |               screen buffer written one char at a time by a host and       |
// |               streams it to the driver as ten command/data words per       |
// |               refresh over the enable_writing / lcd_available handshake:   |
// |                 step 0     : LINE1_CMD          (select_cd = 0)            |
// |                 steps 1-4  : chars  0..15, 4 per word (select_cd = 1)      |
// |                 step 5     : LINE2_CMD          (select_cd = 0)            |
// |                 steps 6-9  : chars 16..31, 4 per word (select_cd = 1)      |
// | Ports       : clk                 system clock (CLOCK_50)                  |
// |               rst                 asynchronous reset, active low           |
// |               wr_en/wr_addr/wr_char  host write, one char per cycle        |
// |               busy                refresh sequence in progress             |
// |               lcd_data            word to driver, leftmost char in [31:24] |
// |               lcd_select_cd       1 = character data, 0 = command          |
// |               lcd_enable_writing  transfer request to driver               |
// |               lcd_available       driver idle/ready                        |
// | Config      : `define LCD_AUTO_REFRESH_EN adds a free-running counter that |
// |               forces a refresh every REFRESH_CYCLES clocks. Without it a   |
// |               refresh only follows reset and host writes.                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lcd_text_feeder #(
    parameter int unsigned REFRESH_CYCLES = 50_000_000,
    parameter logic [7:0]  LINE1_CMD      = 8'h80,
    parameter logic [7:0]  LINE2_CMD      = 8'hC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_char,
    output logic        busy,
    output logic [31:0] lcd_data,
    output logic        lcd_select_cd,
    output logic        lcd_enable_writing,
    input  logic        lcd_available
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_REQ      = 2'd1;
    localparam logic [1:0] c_WAIT_ACK = 2'd2;
    localparam logic [1:0] c_WAIT_RDY = 2'd3;

    localparam logic [3:0] c_LAST_STEP = 4'd9;
    localparam logic [7:0] c_BLANK     = 8'h20;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_step;
    logic        r_dirty;
    logic [31:0] r_data;
    logic        r_sel;
    logic [7:0]  r_buf [32];

    logic        w_tick;
    logic        w_start;
    logic        w_is_cmd;
    logic [7:0]  w_cmd;
    logic [4:0]  w_base;
    logic [31:0] w_word;

    // --------------------------------------------------------------------------
    // Optional periodic refresh tick
    // --------------------------------------------------------------------------
`ifdef LCD_AUTO_REFRESH_EN
    localparam int c_CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [c_CNT_W-1:0] r_refresh_cnt;

    assign w_tick = (r_refresh_cnt == c_CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_cnt <= '0;
        end else if (w_tick) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end
`else
    assign w_tick = 1'b0;
`endif

    // --------------------------------------------------------------------------
    // Screen buffer: host writes land in every state; reset blanks the screen
    // --------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= c_BLANK;
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_char;
        end
    end

    // --------------------------------------------------------------------------
    // Word selection for the current step
    // --------------------------------------------------------------------------
    always_comb begin
        w_is_cmd = 1'b0;
        w_cmd    = LINE1_CMD;
        w_base   = 5'd0;
        case (r_step)
            4'd0: begin
                w_is_cmd = 1'b1;
                w_cmd    = LINE1_CMD;
            end
            4'd5: begin
                w_is_cmd = 1'b1;
                w_cmd    = LINE2_CMD;
            end
            // Steps 1..4 map to char bases 0,4,8,12: (step-1) in the low two bits.
            4'd1, 4'd2, 4'd3, 4'd4: begin
                w_base = {1'b0, r_step[1:0] - 2'd1, 2'b00};
            end
            // Steps 6..9 map to char bases 16,20,24,28: (step-6) in the low two bits.
            4'd6, 4'd7, 4'd8, 4'd9: begin
                w_base = {1'b1, r_step[1:0] - 2'd2, 2'b00};
            end
            default: begin
                w_is_cmd = 1'b1;
                w_cmd    = LINE1_CMD;
            end
        endcase
    end

    always_comb begin
        if (w_is_cmd) begin
            w_word = {24'h0, w_cmd};
        end else begin
            w_word = {r_buf[w_base], r_buf[w_base + 5'd1],
                      r_buf[w_base + 5'd2], r_buf[w_base + 5'd3]};
        end
    end

    // --------------------------------------------------------------------------
    // FSM: state register
    // --------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // --------------------------------------------------------------------------
    // FSM: next-state logic
    // --------------------------------------------------------------------------
    assign w_start = (r_state == c_IDLE) && (r_dirty || w_tick);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_dirty || w_tick) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                w_state_nxt = c_WAIT_ACK;
            end
            c_WAIT_ACK: begin
                // Driver signals acceptance by dropping lcd_available.
                if (!lcd_available) begin
                    w_state_nxt = c_WAIT_RDY;
                end
            end
            c_WAIT_RDY: begin
                if (lcd_available) begin
                    w_state_nxt = (r_step == c_LAST_STEP) ? c_IDLE : c_REQ;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------------------
    // Sequence bookkeeping: step counter, dirty flag, held output word
    // --------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step <= 4'd0;
        end else if (w_start) begin
            r_step <= 4'd0;
        end else if ((r_state == c_WAIT_RDY) && lcd_available && (r_step != c_LAST_STEP)) begin
            r_step <= r_step + 4'd1;
        end
    end

    // Starting a refresh clears dirty, but a host write or tick arriving in the
    // same cycle sets it again so that change gets its own refresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dirty <= 1'b1;
        end else begin
            r_dirty <= (r_dirty && !w_start) || wr_en || (w_tick && !w_start);
        end
    end

    // The word is captured at the end of REQ and held through the handshake,
    // so host writes during WAIT_ACK cannot disturb the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= 32'h0;
            r_sel  <= 1'b1;
        end else if (r_state == c_REQ) begin
            r_data <= w_word;
            r_sel  <= !w_is_cmd;
        end
    end

    // --------------------------------------------------------------------------
    // FSM: outputs
    // --------------------------------------------------------------------------
    always_comb begin
        busy               = (r_state != c_IDLE);
        lcd_enable_writing = (r_state == c_REQ) || (r_state == c_WAIT_ACK);
        lcd_data           = r_data;
        lcd_select_cd      = r_sel;
        if (r_state == c_REQ) begin
            lcd_data      = w_word;
            lcd_select_cd = !w_is_cmd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_text_feeder                                           |
// | Description : Directed self-checking bench for lcd_text_feeder with a      |
// |               behavioural LCD driver that records every accepted word.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_lcd_text_feeder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_char;
    logic        busy;
    logic [31:0] lcd_data;
    logic        lcd_select_cd;
    logic        lcd_enable_writing;
    logic        lcd_available;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_data [$];
    logic        cap_sel  [$];
    int          ack_delay = 0;
    int          hold_cnt  = 0;

    lcd_text_feeder #(.REFRESH_CYCLES(100)) dut (
        .clk                (clk),
        .rst                (rst),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_char            (wr_char),
        .busy               (busy),
        .lcd_data           (lcd_data),
        .lcd_select_cd      (lcd_select_cd),
        .lcd_enable_writing (lcd_enable_writing),
        .lcd_available      (lcd_available)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver model: accepts a request (after ack_delay samples) by dropping
    // lcd_available, then becomes ready again once enable is released.
    initial begin
        lcd_available = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                lcd_available = 1'b1;
                hold_cnt      = 0;
            end else if (lcd_enable_writing && lcd_available) begin
                if (hold_cnt < ack_delay) begin
                    hold_cnt++;
                end else begin
                    cap_data.push_back(lcd_data);
                    cap_sel.push_back(lcd_select_cd);
                    lcd_available = 1'b0;
                    hold_cnt      = 0;
                end
            end else if (!lcd_enable_writing && !lcd_available) begin
                lcd_available = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_char = c;
        @(posedge clk);
        #2;
        wr_en   = 1'b0;
    endtask

    task automatic wait_cap(input int n, input string tag);
        int k = 0;
        while (cap_data.size() < n && k < 500) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk(tag, (cap_data.size() >= n), 1);
    endtask

    // Waits for a refresh to start and finish; ncyc counts the busy cycles.
    task automatic wait_done(output int ncyc, input string tag);
        int k    = 0;
        bit seen = 0;
        ncyc = 0;
        while (!busy && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        while (busy && k < 3000) begin
            seen = 1;
            ncyc++;
            @(posedge clk);
            #2;
            k++;
        end
        chk(tag, (seen && !busy), 1);
    endtask

    task automatic check_seq(input string tag, input logic [31:0] exp [10]);
        chk({tag, "_count"}, cap_data.size(), 10);
        if (cap_data.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("%s_w%0d", tag, i), cap_data[i], exp[i]);
                chk($sformatf("%s_sel%0d", tag, i), {31'h0, cap_sel[i]},
                    ((i == 0) || (i == 5)) ? 32'd0 : 32'd1);
            end
        end
        cap_data.delete();
        cap_sel.delete();
    endtask

    logic [31:0] exp_blank [10];
    logic [31:0] exp_hello [10];
    logic [31:0] exp_c     [10];
    logic [31:0] exp_d     [10];
    logic [31:0] exp_e     [10];

    initial begin
        int ncyc;
        int rises;
        bit prev;
        bit quiet;
        logic [31:0] held;

        exp_blank = '{32'h80, 32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020,
                      32'hC0, 32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020};
        exp_hello = '{32'h80, 32'h48454C4C, 32'h4F202020, 32'h20202020, 32'h20202020,
                      32'hC0, 32'h20202020, 32'h20202020, 32'h20202020, 32'h20202020};
        exp_c     = '{32'h80, 32'h48454C4C, 32'h4F202020, 32'h20202020, 32'h20202020,
                      32'hC0, 32'h57202020, 32'h20202020, 32'h20202020, 32'h20202020};
        exp_d     = '{32'h80, 32'h4845584C, 32'h4F202020, 32'h20202020, 32'h20202020,
                      32'hC0, 32'h57202020, 32'h20202020, 32'h20202020, 32'h20202020};
        exp_e     = '{32'h80, 32'h4845584C, 32'h4F202020, 32'h20202020, 32'h20202020,
                      32'hC0, 32'h57202020, 32'h20202020, 32'h20202020, 32'h2020205A};

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_char = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy",   {31'h0, busy}, 0);
        chk("rst_data",   lcd_data, 32'h0);
        chk("rst_sel",    {31'h0, lcd_select_cd}, 1);
        chk("rst_enable", {31'h0, lcd_enable_writing}, 0);

        // Blank refresh after release; HELLO written once line 2 has begun
        rst = 1'b1;
        wait_cap(6, "a_reach_line2");
        wr(5'd0, 8'h48);
        wr(5'd1, 8'h45);
        wr(5'd2, 8'h4C);
        wr(5'd3, 8'h4C);
        wr(5'd4, 8'h4F);
        wait_done(ncyc, "a_done");
        check_seq("blank", exp_blank);

        // Exactly one follow-up refresh carries HELLO, at 3 cycles per transfer
        wait_done(ncyc, "b_done");
        chk("b_cycles", ncyc, 30);
        check_seq("hello", exp_hello);
        quiet = 1;
        repeat (50) begin
            @(posedge clk);
            #2;
            if (busy) quiet = 0;
        end
        chk("b_no_extra_refresh", {31'h0, quiet}, 1);
        chk("b_no_extra_words", cap_data.size(), 0);

        // Write to an already-sent char during step 7 triggers a second refresh
        wr(5'd16, 8'h57);
        wait_cap(8, "c_reach_step7");
        wr(5'd2, 8'h58);
        wait_done(ncyc, "c_done");
        check_seq("c_seq", exp_c);
        wait_done(ncyc, "d_done");
        chk("d_cycles", ncyc, 30);
        check_seq("d_seq", exp_d);

        // Slow driver: request and word must stay stable while unacknowledged
        ack_delay = 22;
        wr(5'd31, 8'h5A);
        begin
            int k = 0;
            while (!lcd_enable_writing && k < 50) begin
                @(posedge clk);
                #2;
                k++;
            end
        end
        held = lcd_data;
        chk("e_first_word", held, 32'h80);
        chk("e_first_sel", {31'h0, lcd_select_cd}, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            chk($sformatf("e_hold_en%0d", i), {31'h0, lcd_enable_writing}, 1);
            chk($sformatf("e_hold_data%0d", i), lcd_data, 32'h80);
        end
        ack_delay = 0;
        wait_done(ncyc, "e_done");
        check_seq("e_seq", exp_e);

        // Reset in the middle of step 4 aborts at once and re-blanks the screen
        wr(5'd0, 8'h68);
        wait_cap(5, "f_reach_step4");
        chk("f_enable_before", {31'h0, lcd_enable_writing}, 1);
        rst = 1'b0;
        #1;
        chk("f_enable_abort", {31'h0, lcd_enable_writing}, 0);
        chk("f_busy_abort",   {31'h0, busy}, 0);
        chk("f_data_abort",   lcd_data, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        cap_data.delete();
        cap_sel.delete();
        rst = 1'b1;
        wait_done(ncyc, "f_done");
        chk("f_cycles", ncyc, 30);
        check_seq("f_blank", exp_blank);

        // Idle window: periodic refreshes only with auto refresh
        rises = 0;
        prev  = busy;
        repeat (300) begin
            @(posedge clk);
            #2;
            if (busy && !prev) rises++;
            prev = busy;
        end
`ifdef LCD_AUTO_REFRESH_EN
        chk("g_auto_refreshes", rises, 3);
`else
        chk("g_no_refreshes", rises, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
